// File: rtl/fact_arbiter.sv
// fact_arbiter: round-robin arbiter sharing one factorial engine among NREQ
// requesters. Grants in IDLE, pulses eng_go in LAUNCH, waits for eng_done in
// WAIT, then holds the result on a valid/ready handshake in RESP.
// Optional build macro: FACT_ARB_TIMEOUT_EN (aborts WAIT after TIMEOUT cycles
// and reports rsp_err_o=1 with rsp_data_o=0).
module fact_arbiter #(
  parameter int SIZE    = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*SIZE-1:0] req_n_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [SIZE-1:0]      rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 eng_go_o,
  output logic [SIZE-1:0]      eng_n_o,
  input  logic                 eng_done_i,
  input  logic [SIZE-1:0]      eng_result_i,
  output logic                 busy_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [SIZE-1:0] eng_n_q, eng_n_d;
  logic [SIZE-1:0] rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] gnt_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [SIZE-1:0] opnd [NREQ];

  // Unpack the flat operand bus into one entry per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_opnd
    assign opnd[gi] = req_n_i[gi*SIZE +: SIZE];
  end

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;
  logic          tmo_hit;

  // The cycle that would bring the counter to TIMEOUT is the abort cycle.
  assign tmo_hit   = (cnt_q == CW'(TIMEOUT - 1));
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  // Rotating search: first set req bit at or above ptr, wrapping to 0.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req_i[PW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  // Next-state and datapath updates for the grant/launch/wait/respond cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    eng_n_d    = eng_n_q;
    rsp_data_d = rsp_data_q;
    gnt_d      = '0;
`ifdef FACT_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = NREQ'(1) << pick_idx;
          win_d   = pick_idx;
          eng_n_d = opnd[pick_idx];
          ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
`ifdef FACT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (eng_done_i) begin
          rsp_data_d = eng_result_i;
          state_d    = ST_RESP;
`ifdef FACT_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
        end
`ifdef FACT_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready_i[win_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any operation to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      eng_n_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      eng_n_q    <= eng_n_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef FACT_ARB_TIMEOUT_EN
  // WAIT-cycle counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

  // gnt is a same-cycle decision; mask it so reset forces it low too.
  assign gnt_o       = gnt_d & {NREQ{rst_n}};
  assign rsp_valid_o = (state_q == ST_RESP) ? (NREQ'(1) << win_q) : '0;
  assign eng_go_o    = (state_q == ST_LAUNCH);
  assign busy_o      = (state_q != ST_IDLE);
  assign eng_n_o     = eng_n_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_fact_arbiter.sv
// Bench for fact_arbiter: directed steps plus randomized transactions checked
// against a round-robin / factorial reference model.
module tb_fact_arbiter;
  localparam int SIZE = 8;
  localparam int NREQ = 4;
`ifdef FACT_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] req_n;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [SIZE-1:0]      rsp_data;
  logic                 rsp_err;
  logic                 eng_go;
  logic [SIZE-1:0]      eng_n;
  logic                 eng_done;
  logic [SIZE-1:0]      eng_result;
  logic                 busy;

  int total = 0;
  int bad   = 0;
  int mptr  = 0;
  logic [SIZE-1:0] opv [NREQ];

  always #5 clk = ~clk;

  fact_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_n_i(req_n), .gnt_o(gnt),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .eng_go_o(eng_go), .eng_n_o(eng_n),
    .eng_done_i(eng_done), .eng_result_i(eng_result), .busy_o(busy)
  );

  function automatic logic [SIZE-1:0] fact(input logic [SIZE-1:0] n);
    logic [SIZE-1:0] p;
    p = 1;
    for (int i = 2; i <= int'(n); i++) p = SIZE'(int'(p) * i);
    return p;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      logic [NREQ-1:0] m;
      i = (p + k) % NREQ;
      m = NREQ'(1) << i;
      if ((r & m) != '0) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    return (w < 0) ? '0 : (NREQ'(1) << w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_valid"}, 32'(rsp_valid), 0);
    check({tag, "_go"}, 32'(eng_go), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(rsp_err), 0);
    check({tag, "_data"}, 32'(rsp_data), 0);
    check({tag, "_engn"}, 32'(eng_n), 0);
  endtask

  // One full transaction, entered and left a little after a falling edge in IDLE.
  task automatic serve(input logic [NREQ-1:0] rv, input int fix_op, input int dly,
                       input int rdy_wait, input logic [NREQ-1:0] drop);
    int w;
    logic [SIZE-1:0] op, res;
    for (int i = 0; i < NREQ; i++) begin
      opv[i] = (fix_op < 0) ? SIZE'($urandom_range(0, 10)) : SIZE'(fix_op);
      req_n[i*SIZE +: SIZE] = opv[i];
    end
    req = rv;
    #1;
    w = rr_pick(rv, mptr);
    check("grant", 32'(gnt), 32'(onehot(w)));
    check("busy_idle", 32'(busy), 0);
    op   = opv[w];
    res  = fact(op);
    mptr = (w + 1) % NREQ;
    @(negedge clk); #1;
    check("launch_go", 32'(eng_go), 1);
    check("launch_engn", 32'(eng_n), 32'(op));
    check("launch_gnt", 32'(gnt), 0);
    check("launch_busy", 32'(busy), 1);
    @(negedge clk); #1;
    for (int c = 0; c < dly; c++) begin
      check("wait_go", 32'(eng_go), 0);
      check("wait_valid", 32'(rsp_valid), 0);
      @(negedge clk); #1;
    end
    check("wait_go_last", 32'(eng_go), 0);
    check("wait_engn", 32'(eng_n), 32'(op));
    eng_done   = 1'b1;
    eng_result = res;
    @(negedge clk);
    eng_done   = 1'b0;
    eng_result = SIZE'($urandom());
    #1;
    check("resp_valid", 32'(rsp_valid), 32'(onehot(w)));
    check("resp_data", 32'(rsp_data), 32'(res));
    check("resp_err", 32'(rsp_err), 0);
    check("resp_gnt", 32'(gnt), 0);
    rsp_ready = ~onehot(w);
    for (int c = 0; c < rdy_wait; c++) begin
      @(negedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'(onehot(w)));
      check("hold_data", 32'(rsp_data), 32'(res));
      check("hold_gnt", 32'(gnt), 0);
    end
    rsp_ready = '1;
    req = rv & ~drop;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check("back_idle", 32'(busy), 0);
    check("back_valid", 32'(rsp_valid), 0);
    check("back_gnt", 32'(gnt), 32'(onehot(rr_pick(req, mptr))));
    $display("txn req=%b winner=%0d op=%0d result=%0d dly=%0d rdy_wait=%0d", rv, w, op, res, dly, rdy_wait);
  endtask

  initial begin
    int w;
    int dly1;
    rst_n = 1'b0; req = '1; req_n = '0; rsp_ready = '0;
    eng_done = 1'b0; eng_result = '0;
    @(negedge clk); #1;
    check_zero_outputs("reset");
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    mptr = 0;

    // Single requester 1, operand 5, engine answers 120.
    dly1 = (TMO > 11) ? 10 : TMO - 3;
    serve(4'b0010, 5, dly1, 0, 4'b0010);

    // Stray completion pulse in IDLE must not produce a response.
    eng_done = 1'b1; eng_result = 8'h77;
    @(negedge clk); eng_done = 1'b0; #1;
    check("stray_valid", 32'(rsp_valid), 0);
    check("stray_busy", 32'(busy), 0);

    // Result held 20 cycles with other requesters pending and other readys high.
    serve(4'b1011, -1, 3, 20, 4'b1011);

    // Reset asserted during WAIT.
    req = 4'b0100;
    for (int i = 0; i < NREQ; i++) req_n[i*SIZE +: SIZE] = 8'd3;
    #1;
    w = rr_pick(req, mptr);
    check("rstw_gnt", 32'(gnt), 32'(onehot(w)));
    @(negedge clk); req = '0; #1;
    check("rstw_go", 32'(eng_go), 1);
    @(negedge clk); #1;
    check("rstw_busy", 32'(busy), 1);
    req = '1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rstw");
    mptr = 0;
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    // Late engine result from the aborted operation.
    eng_done = 1'b1; eng_result = 8'd6;
    @(negedge clk); eng_done = 1'b0; #1;
    check("late_valid", 32'(rsp_valid), 0);
    check("late_busy", 32'(busy), 0);
    $display("txn reset_during_wait done");

    // All requesters held: expect 0,1,2,3,0 from the reset pointer.
    for (int t = 0; t < 5; t++) serve(4'b1111, -1, t, 0, (t == 4) ? 4'b1111 : 4'b0000);

    // Requester 2 drops its request just before it would win.
    serve(4'b0110, -1, 2, 1, 4'b0110);
    @(negedge clk); #1;
    check("drop_gnt", 32'(gnt), 0);
    check("drop_busy", 32'(busy), 0);

    // Randomized traffic.
    for (int t = 0; t < 16; t++) begin
      serve(NREQ'($urandom_range(1, (1 << NREQ) - 1)), -1, $urandom_range(0, 5),
            $urandom_range(0, 3), NREQ'($urandom()));
    end
    req = '0;
    @(negedge clk);

`ifdef FACT_ARB_TIMEOUT_EN
    // Engine never completes: abort after TMO WAIT cycles.
    req = 4'b0001;
    #1;
    w = rr_pick(req, mptr);
    mptr = (w + 1) % NREQ;
    check("tmo_gnt", 32'(gnt), 32'(onehot(w)));
    @(negedge clk); req = '0; #1;
    check("tmo_go", 32'(eng_go), 1);
    @(negedge clk); #1;
    for (int c = 1; c < TMO; c++) begin
      @(negedge clk); #1;
      check("tmo_wait_valid", 32'(rsp_valid), 0);
    end
    @(negedge clk); #1;
    check("tmo_valid", 32'(rsp_valid), 32'(onehot(w)));
    check("tmo_err", 32'(rsp_err), 1);
    check("tmo_data", 32'(rsp_data), 0);
    rsp_ready = '1;
    @(negedge clk); rsp_ready = '0; #1;
    check("tmo_idle", 32'(busy), 0);
    $display("txn timeout winner=%0d", w);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
